// File: rtl/sdpram_stat_ctrl.sv
// Read-modify-write controller for a statistics counter table in a simple-dual-port RAM.
// Arbitrates an increment stream against a host read / read-clear port, blocks any
// request whose address still has an op in flight, and gates all issue on RAM init-done.
module sdpram_stat_ctrl #(
   parameter int unsigned CNT_W    = 72,
   parameter int unsigned DEPTH    = 128,
   parameter int unsigned ADDR_W   = $clog2(DEPTH),
   parameter int unsigned INC_W    = 16,
   parameter int unsigned RD_LAT   = 2,
   parameter int unsigned SATURATE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc_valid,
   output logic              inc_ready,
   input  logic [ADDR_W-1:0] inc_addr,
   input  logic [INC_W-1:0]  inc_val,
   input  logic              host_req,
   input  logic              host_clr,
   input  logic [ADDR_W-1:0] host_addr,
   output logic              host_ack,
   output logic [CNT_W-1:0]  host_rdata,
   output logic              sat_pulse,
   input  logic              ram_init_done,
   output logic              ram_wea,
   output logic [ADDR_W-1:0] ram_addra,
   output logic [CNT_W-1:0]  ram_dina,
   output logic [ADDR_W-1:0] ram_addrb,
   input  logic [CNT_W-1:0]  ram_doutb
);

   localparam int unsigned PIPE_D = RD_LAT + 1;   // hazard window depth
   localparam int unsigned C_IDX  = RD_LAT - 1;   // stage whose read data is on ram_doutb
   localparam int unsigned SUM_W  = CNT_W + 1;
   localparam bit          SAT_EN = (SATURATE != 0);

   typedef enum logic {INIT_WAIT, RUN} state_e;

   state_e              state_q, state_d;
   logic [PIPE_D-1:0]   vld_q, vld_d;
   logic [ADDR_W-1:0]   addr_q [PIPE_D];
   logic [ADDR_W-1:0]   addr_d [PIPE_D];
   logic [RD_LAT-1:0]   host_q, host_d;
   logic [RD_LAT-1:0]   clr_q, clr_d;
   logic [INC_W-1:0]    val_q [RD_LAT];
   logic [INC_W-1:0]    val_d [RD_LAT];
   logic                pend_q, pend_d;
   logic                last_host_q, last_host_d;
   logic [ADDR_W-1:0]   addrb_q, addrb_d;
   logic                wea_q, wea_d;
   logic [ADDR_W-1:0]   addra_q, addra_d;
   logic [CNT_W-1:0]    dina_q, dina_d;
   logic                sat_q, sat_d;
   logic                ack_q, ack_d;
   logic [CNT_W-1:0]    rdata_q, rdata_d;

   logic                haz_inc, haz_host, run;
   logic                inc_elig, host_elig, grant_inc, grant_host, issue;
   logic [ADDR_W-1:0]   issue_addr;
   logic [SUM_W-1:0]    sum;

   assign host_ack   = ack_q;
   assign host_rdata = rdata_q;
   assign sat_pulse  = sat_q;
   assign ram_wea    = wea_q;
   assign ram_addra  = addra_q;
   assign ram_dina   = dina_q;

   // Hazard check, arbitration, issue pipeline, completion and FSM next state
   always_comb begin
      state_d     = state_q;
      vld_d       = '0;
      host_d      = '0;
      clr_d       = '0;
      for (int unsigned i = 0; i < PIPE_D; i++) addr_d[i] = addr_q[i];
      for (int unsigned i = 0; i < RD_LAT; i++) val_d[i] = val_q[i];
      pend_d      = pend_q;
      last_host_d = last_host_q;
      wea_d       = 1'b0;
      addra_d     = addra_q;
      dina_d      = dina_q;
      sat_d       = 1'b0;
      ack_d       = 1'b0;
      rdata_d     = rdata_q;
      haz_inc     = 1'b0;
      haz_host    = 1'b0;

      for (int unsigned i = 0; i < PIPE_D; i++) begin
         if (vld_q[i] && (addr_q[i] == inc_addr))  haz_inc  = 1'b1;
         if (vld_q[i] && (addr_q[i] == host_addr)) haz_host = 1'b1;
      end

      run        = (state_q == RUN);
      inc_elig   = inc_valid & run & ~haz_inc;
      host_elig  = host_req & ~pend_q & run & ~haz_host;
      grant_inc  = inc_elig & (~host_elig | last_host_q);
      grant_host = host_elig & ~grant_inc;
      issue      = grant_inc | grant_host;
      issue_addr = grant_host ? host_addr : inc_addr;
      inc_ready  = grant_inc;
      ram_addrb  = issue ? issue_addr : addrb_q;
      addrb_d    = ram_addrb;

      if (grant_inc)       last_host_d = 1'b0;
      else if (grant_host) last_host_d = 1'b1;

      // pending stays set through the ack cycle so a held request is not re-issued there
      if (grant_host)  pend_d = 1'b1;
      else if (ack_q)  pend_d = 1'b0;

      vld_d[0]  = issue;
      addr_d[0] = issue_addr;
      host_d[0] = grant_host;
      clr_d[0]  = host_clr;
      val_d[0]  = inc_val;
      for (int unsigned i = 1; i < PIPE_D; i++) begin
         vld_d[i]  = vld_q[i-1];
         addr_d[i] = addr_q[i-1];
      end
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         host_d[i] = host_q[i-1];
         clr_d[i]  = clr_q[i-1];
         val_d[i]  = val_q[i-1];
      end

      sum = SUM_W'(ram_doutb) + SUM_W'(val_q[C_IDX]);
      if (vld_q[C_IDX]) begin
         addra_d = addr_q[C_IDX];
         if (host_q[C_IDX]) begin
            ack_d   = 1'b1;
            rdata_d = ram_doutb;
            if (clr_q[C_IDX]) begin
               wea_d  = 1'b1;
               dina_d = '0;
            end
         end else begin
            wea_d = 1'b1;
            if (SAT_EN && sum[CNT_W]) begin
               dina_d = '1;
               sat_d  = 1'b1;
            end else begin
               dina_d = sum[CNT_W-1:0];
            end
         end
      end

      case (state_q)
         INIT_WAIT: if (ram_init_done)  state_d = RUN;
         RUN:       if (!ram_init_done) state_d = INIT_WAIT;
         default:   state_d = INIT_WAIT;
      endcase
   end

   // State and pipeline registers; reset discards any in-flight op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= INIT_WAIT;
         vld_q       <= '0;
         for (int unsigned i = 0; i < PIPE_D; i++) addr_q[i] <= '0;
         host_q      <= '0;
         clr_q       <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) val_q[i] <= '0;
         pend_q      <= 1'b0;
         last_host_q <= 1'b1;
         addrb_q     <= '0;
         wea_q       <= 1'b0;
         addra_q     <= '0;
         dina_q      <= '0;
         sat_q       <= 1'b0;
         ack_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         vld_q       <= vld_d;
         for (int unsigned i = 0; i < PIPE_D; i++) addr_q[i] <= addr_d[i];
         host_q      <= host_d;
         clr_q       <= clr_d;
         for (int unsigned i = 0; i < RD_LAT; i++) val_q[i] <= val_d[i];
         pend_q      <= pend_d;
         last_host_q <= last_host_d;
         addrb_q     <= addrb_d;
         wea_q       <= wea_d;
         addra_q     <= addra_d;
         dina_q      <= dina_d;
         sat_q       <= sat_d;
         ack_q       <= ack_d;
         rdata_q     <= rdata_d;
      end
   end

endmodule

// File: tb/tb_sdpram_stat_ctrl.sv
// Directed bench for sdpram_stat_ctrl: a saturating and a wrapping instance share stimulus,
// each with its own 2-cycle-latency RAM model.
module tb_sdpram_stat_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        inc_valid, host_req, host_clr, ram_init_done;
   logic [6:0]  inc_addr, host_addr;
   logic [15:0] inc_val;

   logic        inc_ready, host_ack, sat_pulse, ram_wea;
   logic [71:0] host_rdata, ram_dina, ram_doutb;
   logic [6:0]  ram_addra, ram_addrb;

   logic        inc_ready_w, host_ack_w, sat_pulse_w, ram_wea_w;
   logic [71:0] host_rdata_w, ram_dina_w, ram_doutb_w;
   logic [6:0]  ram_addra_w, ram_addrb_w;

   logic        tb_we;
   logic [6:0]  tb_wa;
   logic [71:0] tb_wd;

   logic [71:0] mem   [128];
   logic [71:0] mem_w [128];
   logic [71:0] rd1, rd1_w;

   int n_chk = 0;
   int errs  = 0;

   always #5 clk = ~clk;

   sdpram_stat_ctrl #(.SATURATE(1)) dut (
      .clk(clk), .rst_n(rst_n), .inc_valid(inc_valid), .inc_ready(inc_ready),
      .inc_addr(inc_addr), .inc_val(inc_val), .host_req(host_req), .host_clr(host_clr),
      .host_addr(host_addr), .host_ack(host_ack), .host_rdata(host_rdata),
      .sat_pulse(sat_pulse), .ram_init_done(ram_init_done), .ram_wea(ram_wea),
      .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_addrb(ram_addrb),
      .ram_doutb(ram_doutb));

   sdpram_stat_ctrl #(.SATURATE(0)) dut_w (
      .clk(clk), .rst_n(rst_n), .inc_valid(inc_valid), .inc_ready(inc_ready_w),
      .inc_addr(inc_addr), .inc_val(inc_val), .host_req(host_req), .host_clr(host_clr),
      .host_addr(host_addr), .host_ack(host_ack_w), .host_rdata(host_rdata_w),
      .sat_pulse(sat_pulse_w), .ram_init_done(ram_init_done), .ram_wea(ram_wea_w),
      .ram_addra(ram_addra_w), .ram_dina(ram_dina_w), .ram_addrb(ram_addrb_w),
      .ram_doutb(ram_doutb_w));

   // RAM models: read-first, two-cycle read latency, cleared while reset is low
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 128; i++) begin
            mem[i]   <= '0;
            mem_w[i] <= '0;
         end
      end else if (tb_we) begin
         mem[tb_wa]   <= tb_wd;
         mem_w[tb_wa] <= tb_wd;
      end else begin
         if (ram_wea)   mem[ram_addra]     <= ram_dina;
         if (ram_wea_w) mem_w[ram_addra_w] <= ram_dina_w;
      end
      rd1         <= mem[ram_addrb];
      ram_doutb   <= rd1;
      rd1_w       <= mem_w[ram_addrb_w];
      ram_doutb_w <= rd1_w;
   end

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_chk++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the drive point of the next cycle; checks follow a #1 after driving
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic preload(input logic [6:0] a, input logic [71:0] d);
      tick();
      tb_we = 1'b1; tb_wa = a; tb_wd = d;
      tick();
      tb_we = 1'b0;
   endtask

   task automatic host_op(input logic [6:0] a, input logic c, output logic [71:0] d,
                          output int lat);
      lat = 0;
      tick();
      host_req = 1'b1; host_clr = c; host_addr = a;
      #1;
      while (!host_ack && lat < 20) begin
         tick(); #1; lat++;
      end
      chk("host_ack_seen", 72'(host_ack), 72'd1);
      d = host_rdata;
      tick();
      host_req = 1'b0; host_clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [71:0] d;
      int          lat, acc, t_acc [4], first_acc, ack_c;

      rst_n = 1'b0; inc_valid = 1'b0; host_req = 1'b0; host_clr = 1'b0;
      ram_init_done = 1'b0; inc_addr = '0; host_addr = '0; inc_val = '0;
      tb_we = 1'b0; tb_wa = '0; tb_wd = '0;

      // Reset state
      repeat (3) tick();
      #1;
      chk("rst_inc_ready", 72'(inc_ready), 72'd0);
      chk("rst_wea", 72'(ram_wea), 72'd0);
      chk("rst_ack", 72'(host_ack), 72'd0);
      chk("rst_sat", 72'(sat_pulse), 72'd0);
      chk("rst_addrb", 72'(ram_addrb), 72'd0);
      chk("rst_rdata", host_rdata, 72'd0);

      // 1: gated while init not done, first accept one cycle after init_done rises
      tick();
      rst_n = 1'b1; inc_valid = 1'b1; inc_addr = 7'd10; inc_val = 16'd5;
      for (int i = 0; i < 10; i++) begin
         tick(); #1;
         chk("init_inc_ready", 72'(inc_ready), 72'd0);
         chk("init_wea", 72'(ram_wea), 72'd0);
      end
      tick(); ram_init_done = 1'b1; #1;
      chk("init_rise_ready", 72'(inc_ready), 72'd0);
      tick(); #1;
      chk("init_first_accept", 72'(inc_ready), 72'd1);
      chk("init_addrb", 72'(ram_addrb), 72'd10);
      tick(); inc_valid = 1'b0; #1;
      chk("init_wea_t1", 72'(ram_wea), 72'd0);
      tick(); #1;
      chk("init_wea_t2", 72'(ram_wea), 72'd0);
      tick(); #1;
      chk("init_wea_t3", 72'(ram_wea), 72'd1);
      chk("init_addra", 72'(ram_addra), 72'd10);
      chk("init_dina", ram_dina, 72'd5);
      tick(); #1;
      chk("init_wea_t4", 72'(ram_wea), 72'd0);

      // 2: same-address incs are spaced by the in-flight window
      acc = 0;
      for (int c = 0; c < 40 && acc < 4; c++) begin
         tick();
         inc_valid = 1'b1; inc_addr = 7'd3; inc_val = 16'd1;
         #1;
         if (inc_ready) begin
            t_acc[acc] = c;
            acc++;
         end
      end
      tick(); inc_valid = 1'b0;
      chk("b2b_accepts", 72'(acc), 72'd4);
      chk("b2b_first", 72'(t_acc[0]), 72'd0);
      chk("b2b_gap1", 72'(t_acc[1] - t_acc[0]), 72'd4);
      chk("b2b_gap2", 72'(t_acc[2] - t_acc[1]), 72'd4);
      chk("b2b_gap3", 72'(t_acc[3] - t_acc[2]), 72'd4);
      repeat (4) tick();
      host_op(7'd3, 1'b0, d, lat);
      chk("b2b_host_val", d, 72'd4);
      chk("host_latency", 72'(lat), 72'd3);

      // 3: distinct addresses issue every cycle, writes land at t+3..t+6
      for (int i = 0; i < 4; i++) begin
         tick();
         inc_valid = 1'b1; inc_addr = 7'(i); inc_val = 16'(i + 1);
         #1;
         chk("seq_accept", 72'(inc_ready), 72'd1);
         if (i == 3) begin
            chk("seq_w0_wea", 72'(ram_wea), 72'd1);
            chk("seq_w0_addr", 72'(ram_addra), 72'd0);
            chk("seq_w0_data", ram_dina, 72'd1);
         end
      end
      tick(); inc_valid = 1'b0; #1;
      chk("seq_w1_addr", 72'(ram_addra), 72'd1);
      chk("seq_w1_data", ram_dina, 72'd2);
      tick(); #1;
      chk("seq_w2_addr", 72'(ram_addra), 72'd2);
      chk("seq_w2_data", ram_dina, 72'd3);
      tick(); #1;
      chk("seq_w3_wea", 72'(ram_wea), 72'd1);
      chk("seq_w3_addr", 72'(ram_addra), 72'd3);
      chk("seq_w3_data", ram_dina, 72'd8);

      // 4: carry-out saturates on one instance and wraps on the other
      preload(7'd5, {{71{1'b1}}, 1'b0});
      inc_valid = 1'b1; inc_addr = 7'd5; inc_val = 16'd3;
      #1;
      chk("sat_accept", 72'(inc_ready), 72'd1);
      tick(); inc_valid = 1'b0;
      tick(); #1;
      chk("sat_early", 72'(sat_pulse), 72'd0);
      tick(); #1;
      chk("sat_wea", 72'(ram_wea), 72'd1);
      chk("sat_data", ram_dina, {72{1'b1}});
      chk("sat_pulse", 72'(sat_pulse), 72'd1);
      chk("wrap_data", ram_dina_w, 72'd1);
      chk("wrap_pulse", 72'(sat_pulse_w), 72'd0);
      tick(); #1;
      chk("sat_pulse_drop", 72'(sat_pulse), 72'd0);

      // 5: read-clear against a competing inc stream on the same counter
      preload(7'd7, 72'd9);
      acc = 0; first_acc = -1; ack_c = -1;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) tick();
         inc_valid = 1'b1; inc_addr = 7'd7; inc_val = 16'd1;
         host_req = (ack_c < 0); host_clr = 1'b1; host_addr = 7'd7;
         #1;
         if (inc_ready) begin
            acc++;
            if (first_acc < 0) first_acc = c;
         end
         if (host_ack && ack_c < 0) begin
            ack_c = c;
            chk("clr_rdata", host_rdata, 72'd9);
            chk("clr_wea", 72'(ram_wea), 72'd1);
            chk("clr_addr", 72'(ram_addra), 72'd7);
            chk("clr_data", ram_dina, 72'd0);
         end
      end
      tick(); inc_valid = 1'b0; host_req = 1'b0; host_clr = 1'b0;
      chk("clr_ack_cycle", 72'(ack_c), 72'd3);
      chk("clr_first_inc", 72'(first_acc), 72'd4);
      chk("clr_inc_count", 72'(acc), 72'd4);
      repeat (4) tick();
      host_op(7'd7, 1'b0, d, lat);
      chk("clr_after_sum", d, 72'(acc));

      // 6: round-robin with both eligible, then reset while ops are in flight
      tick();
      inc_valid = 1'b1; inc_addr = 7'd20; inc_val = 16'd1;
      host_req = 1'b1; host_clr = 1'b1; host_addr = 7'd21;
      #1;
      chk("rr0_inc", 72'(inc_ready), 72'd1);
      chk("rr0_addrb", 72'(ram_addrb), 72'd20);
      tick(); inc_addr = 7'd22; #1;
      chk("rr1_inc", 72'(inc_ready), 72'd0);
      chk("rr1_addrb", 72'(ram_addrb), 72'd21);
      tick(); inc_addr = 7'd24; #1;
      chk("rr2_inc", 72'(inc_ready), 72'd1);
      chk("rr2_addrb", 72'(ram_addrb), 72'd24);
      tick(); rst_n = 1'b0; #1;
      chk("mrst_wea", 72'(ram_wea), 72'd0);
      chk("mrst_ack", 72'(host_ack), 72'd0);
      tick(); inc_valid = 1'b0; host_req = 1'b0; host_clr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i == 2) rst_n = 1'b1;
         #1;
         chk("mrst_ack_quiet", 72'(host_ack), 72'd0);
         chk("mrst_wea_quiet", 72'(ram_wea), 72'd0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errs, n_chk);
      $finish;
   end

endmodule
